// File: rtl/line_mem_responder_pkg.sv
// Shared cache package: line geometry and the responder FSM state type.
package line_mem_responder_pkg;

    localparam int LINE_W        = 128;
    localparam int LINE_OFFSET_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_e;

    // Index width for a given line count; never narrower than one bit.
    function automatic int idx_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/line_mem_responder_line_ram.sv
// line_ram: single-port line storage, synchronous write, registered read.
module line_ram #(
    parameter int DEPTH  = 1024,
    parameter int ADDR_W = 10,
    parameter int DATA_W = 128
) (
    input  logic              clk_i,
    input  logic              en_i,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [DATA_W-1:0] wdata_i,
    output logic [DATA_W-1:0] rdata_o
);

    logic [DATA_W-1:0] mem_reg [DEPTH];
    logic [DATA_W-1:0] rdata_reg;

    // No reset on storage or read register so this maps onto block RAM.
    always_ff @(posedge clk_i) begin
        if (en_i) begin
            if (we_i) begin
                mem_reg[addr_i] <= wdata_i;
            end else begin
                rdata_reg <= mem_reg[addr_i];
            end
        end
    end

    assign rdata_o = rdata_reg;

endmodule

// File: rtl/line_mem_responder.sv
// Fixed-latency cache line memory responder (IDLE/WAIT/RESP) over a line_ram.
// Optional LINE_MEM_STATS_EN adds read/write response counters.
module line_mem_responder
    import line_mem_responder_pkg::*;
#(
    parameter int DEPTH_LINES = 1024,
    parameter int LATENCY     = 4
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              mem_cs_i,
    input  logic              mem_we_i,
    input  logic [31:0]       mem_addr_i,
    input  logic [LINE_W-1:0] mem_wdata_i,
    output logic [LINE_W-1:0] mem_rdata_o,
    output logic              mem_rvalid_o,
    output logic              busy_o
`ifdef LINE_MEM_STATS_EN
    ,
    output logic [31:0]       rd_cnt_o,
    output logic [31:0]       wr_cnt_o
`endif
);

    localparam int IDX_W = idx_width(DEPTH_LINES);
    localparam int CNT_W = $clog2(LATENCY + 1);

    state_e             state_reg, state_next;
    logic [CNT_W-1:0]   cnt_reg;
    logic               we_reg;
    logic [IDX_W-1:0]   idx_reg;
    logic [LINE_W-1:0]  wdata_reg;
    logic [LINE_W-1:0]  rdata_hold_reg;

    logic               capture;
    logic               commit;
    logic               ram_we;
    logic [IDX_W-1:0]   ram_addr;
    logic [LINE_W-1:0]  ram_wdata;
    logic [LINE_W-1:0]  ram_rdata;
    logic [IDX_W-1:0]   addr_idx;
    logic               unused_addr;

    assign addr_idx    = mem_addr_i[LINE_OFFSET_W +: IDX_W];
    assign unused_addr = &{1'b0, mem_addr_i};

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (mem_cs_i) state_next = (LATENCY > 1) ? WAIT : RESP;
            WAIT:    if (cnt_reg == CNT_W'(1)) state_next = RESP;
            RESP:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // With LATENCY=1 the RAM access happens on the capture edge itself,
    // so the RAM is fed straight from the request inputs in that case.
    always_comb begin
        capture      = (state_reg == IDLE) && mem_cs_i;
        commit       = (state_next == RESP) && (state_reg != RESP) && !rst_i;
        ram_we       = capture ? mem_we_i    : we_reg;
        ram_addr     = capture ? addr_idx    : idx_reg;
        ram_wdata    = capture ? mem_wdata_i : wdata_reg;
        mem_rvalid_o = (state_reg == RESP);
        busy_o       = (state_reg != IDLE);
        mem_rdata_o  = ((state_reg == RESP) && !we_reg) ? ram_rdata : rdata_hold_reg;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_reg        <= '0;
            rdata_hold_reg <= '0;
        end else begin
            if (capture) begin
                cnt_reg <= CNT_W'(LATENCY - 1);
            end else if (state_reg == WAIT) begin
                cnt_reg <= cnt_reg - CNT_W'(1);
            end
            if ((state_reg == RESP) && !we_reg) begin
                rdata_hold_reg <= ram_rdata;
            end
        end
    end

    // Request capture registers carry no reset; they are only consumed
    // after a capture has loaded them.
    always_ff @(posedge clk_i) begin
        if (capture) begin
            we_reg    <= mem_we_i;
            idx_reg   <= addr_idx;
            wdata_reg <= mem_wdata_i;
        end
    end

    line_ram #(
        .DEPTH  (DEPTH_LINES),
        .ADDR_W (IDX_W),
        .DATA_W (LINE_W)
    ) u_line_ram (
        .clk_i   (clk_i),
        .en_i    (commit),
        .we_i    (ram_we),
        .addr_i  (ram_addr),
        .wdata_i (ram_wdata),
        .rdata_o (ram_rdata)
    );

`ifdef LINE_MEM_STATS_EN
    logic [31:0] rd_cnt_reg, wr_cnt_reg;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rd_cnt_reg <= '0;
            wr_cnt_reg <= '0;
        end else if (state_reg == RESP) begin
            if (we_reg) wr_cnt_reg <= wr_cnt_reg + 32'd1;
            else        rd_cnt_reg <= rd_cnt_reg + 32'd1;
        end
    end

    assign rd_cnt_o = rd_cnt_reg;
    assign wr_cnt_o = wr_cnt_reg;
`endif

endmodule

// File: tb/tb_line_mem_responder.sv
// Scoreboard bench for line_mem_responder: one LATENCY=4 and one LATENCY=1 instance.
module tb_line_mem_responder;
    import line_mem_responder_pkg::*;

    localparam int LAT_A = 4;
    localparam int LAT_B = 1;

    localparam logic [127:0] D0   = 128'h0123456789ABCDEF0123456789ABCDEF;
    localparam logic [127:0] D1   = 128'hDEADBEEFCAFEF00D01020304A5A55A5A;
    localparam logic [127:0] DAA  = {16{8'hAA}};
    localparam logic [127:0] D11  = {16{8'h11}};
    localparam logic [127:0] D55  = {16{8'h55}};
    localparam logic [127:0] DX   = 128'h00000000FFFFFFFF1234567887654321;
    localparam logic [127:0] DY   = 128'hFEDCBA98765432100F1E2D3C4B5A6978;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic         a_rst, a_cs, a_we, a_rvalid, a_busy;
    logic [31:0]  a_addr;
    logic [127:0] a_wdata, a_rdata;
    logic         b_rst, b_cs, b_we, b_rvalid, b_busy;
    logic [31:0]  b_addr;
    logic [127:0] b_wdata, b_rdata;
`ifdef LINE_MEM_STATS_EN
    logic [31:0]  a_rd_cnt, a_wr_cnt, b_rd_cnt, b_wr_cnt;
`endif

    line_mem_responder #(.DEPTH_LINES(1024), .LATENCY(LAT_A)) dut_a (
        .clk_i        (clk),
        .rst_i        (a_rst),
        .mem_cs_i     (a_cs),
        .mem_we_i     (a_we),
        .mem_addr_i   (a_addr),
        .mem_wdata_i  (a_wdata),
        .mem_rdata_o  (a_rdata),
        .mem_rvalid_o (a_rvalid),
        .busy_o       (a_busy)
`ifdef LINE_MEM_STATS_EN
        ,
        .rd_cnt_o     (a_rd_cnt),
        .wr_cnt_o     (a_wr_cnt)
`endif
    );

    line_mem_responder #(.DEPTH_LINES(16), .LATENCY(LAT_B)) dut_b (
        .clk_i        (clk),
        .rst_i        (b_rst),
        .mem_cs_i     (b_cs),
        .mem_we_i     (b_we),
        .mem_addr_i   (b_addr),
        .mem_wdata_i  (b_wdata),
        .mem_rdata_o  (b_rdata),
        .mem_rvalid_o (b_rvalid),
        .busy_o       (b_busy)
`ifdef LINE_MEM_STATS_EN
        ,
        .rd_cnt_o     (b_rd_cnt),
        .wr_cnt_o     (b_wr_cnt)
`endif
    );

    typedef struct {
        logic [127:0] data;
        int           cap;
    } exp_t;

    exp_t qa[$];
    exp_t qb[$];
    exp_t ea, eb;
    int vectors = 0;
    int miscompares = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
        end else begin
            $display("ok   %s: %h (cycle %0d)", name, act, cyc);
        end
    endtask

    // Monitors: every rvalid pops one expectation; a pulse with nothing pending is an error.
    always @(negedge clk) begin
        if (a_rvalid === 1'b1) begin
            if (qa.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL a_spurious_rvalid: got rvalid=1, expected 0 (cycle %0d)", cyc);
            end else begin
                ea = qa.pop_front();
                chk("a_rdata", a_rdata, ea.data);
                chk("a_latency", 128'(cyc - ea.cap + 1), 128'(LAT_A));
            end
        end
    end

    always @(negedge clk) begin
        if (b_rvalid === 1'b1) begin
            if (qb.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL b_spurious_rvalid: got rvalid=1, expected 0 (cycle %0d)", cyc);
            end else begin
                eb = qb.pop_front();
                chk("b_rdata", b_rdata, eb.data);
                chk("b_latency", 128'(cyc - eb.cap + 1), 128'(LAT_B));
            end
        end
    end

    // Issue one request and hold cs until the rvalid negedge. chain=1 means
    // we are already at a RESP negedge, so capture is two edges away.
    task automatic req(input bit sel, input logic we, input logic [31:0] addr,
                       input logic [127:0] wd, input logic [127:0] exp, input bit chain);
        int   nb;
        bit   seen;
        exp_t e;
        if (!chain) @(negedge clk);
        e.data = exp;
        e.cap  = chain ? cyc + 2 : cyc + 1;
        if (sel == 1'b0) begin
            a_cs = 1'b1; a_we = we; a_addr = addr; a_wdata = wd;
            qa.push_back(e);
        end else begin
            b_cs = 1'b1; b_we = we; b_addr = addr; b_wdata = wd;
            qb.push_back(e);
        end
        nb   = 0;
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            if (sel == 1'b0) begin
                if (a_busy) nb++;
                seen = a_rvalid;
            end else begin
                if (b_busy) nb++;
                seen = b_rvalid;
            end
        end
        if (!seen) begin
            vectors++;
            miscompares++;
            $display("FAIL %s_timeout: got no rvalid in 20 cycles, expected one", sel ? "b" : "a");
        end else begin
            chk(sel ? "b_busy_cycles" : "a_busy_cycles", 128'(nb), 128'(sel ? LAT_B : LAT_A));
        end
    endtask

    task automatic rel(input bit sel);
        if (sel == 1'b0) a_cs = 1'b0;
        else             b_cs = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish, expected end of test");
        $fatal(1, "watchdog expired");
    end

    initial begin
        a_rst = 1'b1; a_cs = 1'b0; a_we = 1'b0; a_addr = '0; a_wdata = '0;
        b_rst = 1'b1; b_cs = 1'b0; b_we = 1'b0; b_addr = '0; b_wdata = '0;
        repeat (3) @(negedge clk);
        chk("a_reset_rvalid", 128'(a_rvalid), 128'(0));
        chk("a_reset_busy",   128'(a_busy),   128'(0));
        chk("a_reset_rdata",  a_rdata,        128'(0));
        chk("b_reset_busy",   128'(b_busy),   128'(0));
        a_rst = 1'b0;
        b_rst = 1'b0;
        repeat (3) @(negedge clk);
        chk("a_idle_busy", 128'(a_busy), 128'(0));

        // Write then offset-read of the same line; writes leave rdata unchanged.
        req(0, 1'b1, 32'h0000_0040, D0, 128'(0), 0);   rel(0);
        req(0, 1'b0, 32'h0000_004C, '0, D0, 0);        rel(0);
        // Back-to-back write then read of the same line.
        req(0, 1'b1, 32'h0000_0080, D1, D0, 0);
        req(0, 1'b0, 32'h0000_0080, '0, D1, 1);        rel(0);
        // Upper address bits wrap modulo 1024 lines.
        req(0, 1'b1, 32'h0000_4010, DAA, D1, 0);       rel(0);
        req(0, 1'b0, 32'h0000_0010, '0, DAA, 0);       rel(0);
        req(0, 1'b1, 32'h0000_0030, D11, DAA, 0);      rel(0);

        // Reset two cycles into a pending write: the write must be dropped.
        @(negedge clk);
        a_cs = 1'b1; a_we = 1'b1; a_addr = 32'h0000_0030; a_wdata = D55;
        repeat (2) @(negedge clk);
        a_rst = 1'b1;
        a_cs  = 1'b0;
        #1;
        chk("a_midrst_rvalid", 128'(a_rvalid), 128'(0));
        chk("a_midrst_busy",   128'(a_busy),   128'(0));
        chk("a_midrst_rdata",  a_rdata,        128'(0));
        repeat (2) @(negedge clk);
        a_rst = 1'b0;
        repeat (4) @(negedge clk);
        chk("a_postrst_rdata", a_rdata, 128'(0));
        chk("a_postrst_busy",  128'(a_busy), 128'(0));
        req(0, 1'b0, 32'h0000_0030, '0, D11, 0);       rel(0);

        // LATENCY=1 instance: 2 writes, 3 reads, including back-to-back and wrap.
        req(1, 1'b1, 32'h0000_0010, DX, 128'(0), 0);
        req(1, 1'b0, 32'h0000_0010, '0, DX, 1);        rel(1);
        req(1, 1'b1, 32'h0000_0020, DY, DX, 0);        rel(1);
        req(1, 1'b0, 32'h0000_0028, '0, DY, 0);
        req(1, 1'b0, 32'h0000_0110, '0, DX, 1);        rel(1);
        repeat (3) @(negedge clk);
        chk("b_final_busy", 128'(b_busy), 128'(0));
        chk("a_queue_empty", 128'(qa.size()), 128'(0));
        chk("b_queue_empty", 128'(qb.size()), 128'(0));
`ifdef LINE_MEM_STATS_EN
        chk("b_rd_cnt", 128'(b_rd_cnt), 128'(3));
        chk("b_wr_cnt", 128'(b_wr_cnt), 128'(2));
        chk("a_rd_cnt_after_reset", 128'(a_rd_cnt), 128'(1));
        chk("a_wr_cnt_after_reset", 128'(a_wr_cnt), 128'(0));
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
